dbg_apb_regs: RTL and testbench

APB responder that terminates the debug port's APB initiator. It provides a small bank of control and status registers that a host reaches over UART. The block holds the identification, scratch, control, sticky status and cycle-counter registers. It answers each transfer with a registered `o_pready` / `o_prdata` handshake.

---
 rtl/dbg_apb_regs_pkg.sv | 23 ++
 rtl/dbg_apb_regs.sv | 201 ++++++++++++++++++++
 tb/tb_dbg_apb_regs.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_apb_regs_pkg.sv
// Shared constants and types for the debug-port APB register bank.
package dbg_apb_regs_pkg;

   localparam int unsigned DATA_W          = 32;
   localparam int unsigned OFF_W           = 6;
   localparam int unsigned STATUS_STICKY_W = 16;
   localparam int unsigned STATUS_LIVE_W   = 16;
   localparam int unsigned WAIT_W          = 4;

   localparam logic [OFF_W-1:0] OFF_ID      = 6'h00;
   localparam logic [OFF_W-1:0] OFF_SCRATCH = 6'h01;
   localparam logic [OFF_W-1:0] OFF_CTRL    = 6'h02;
   localparam logic [OFF_W-1:0] OFF_STATUS  = 6'h03;
   localparam logic [OFF_W-1:0] OFF_CYCLE   = 6'h04;
   localparam logic [OFF_W-1:0] OFF_WAIT    = 6'h05;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dbg_apb_regs.sv
// APB responder holding ID, SCRATCH, CTRL, sticky STATUS and CYCLE registers.
// Define DBG_APB_REGS_WAIT_EN to add the WAIT register and programmable wait states.
module dbg_apb_regs
   import dbg_apb_regs_pkg::*;
#(
   parameter logic [31:0] ID_VALUE  = 32'h0D8C_0001,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_penable,
   input  logic                       i_pwrite,
   input  logic [31:0]                i_paddr,
   input  logic [DATA_W-1:0]          i_pwdata,
   output logic                       o_pready,
   output logic [DATA_W-1:0]          o_prdata,
   output logic [DATA_W-1:0]          o_ctrl,
   input  logic [STATUS_STICKY_W-1:0] i_status_set,
   input  logic [STATUS_LIVE_W-1:0]   i_status_live,
   output logic                       o_decerr
);

   state_e                     state_q, state_d;
   logic                       hit_q, hit_d;
   logic [OFF_W-1:0]           off_q, off_d;
   logic                       write_q, write_d;
   logic [DATA_W-1:0]          wdata_q, wdata_d;
   logic [WAIT_W-1:0]          cnt_q, cnt_d;
   logic                       pready_q, pready_d;
   logic [DATA_W-1:0]          prdata_q, prdata_d;
   logic                       decerr_q, decerr_d;

   logic [DATA_W-1:0]          scratch_q, scratch_d;
   logic [DATA_W-1:0]          ctrl_q, ctrl_d;
   logic [DATA_W-1:0]          cycle_q, cycle_d;
   logic [STATUS_STICKY_W-1:0] sticky_q, sticky_d;
   logic [STATUS_STICKY_W-1:0] w1c_c;
`ifdef DBG_APB_REGS_WAIT_EN
   logic [WAIT_W-1:0]          wait_q, wait_d;
`endif

   logic                       in_hit_c;
   logic                       sel_hit_c;
   logic [OFF_W-1:0]           sel_off_c;
   logic                       rd_map_c;
   logic [DATA_W-1:0]          rd_data_c;
   logic [WAIT_W-1:0]          wait_cnt_c;
   logic                       commit_c;
   logic                       unused_paddr_lo;

   assign unused_paddr_lo = ^i_paddr[1:0];
   assign in_hit_c        = (i_paddr[31:8] == BASE_ADDR[31:8]);

   // In IDLE the read value comes from the live bus; later it comes from the latched address.
   assign sel_hit_c = (state_q == ST_IDLE) ? in_hit_c     : hit_q;
   assign sel_off_c = (state_q == ST_IDLE) ? i_paddr[7:2] : off_q;

`ifdef DBG_APB_REGS_WAIT_EN
   assign wait_cnt_c = wait_q;
`else
   assign wait_cnt_c = '0;
`endif

   // Read mux and map decode
   always_comb begin
      rd_map_c  = 1'b0;
      rd_data_c = '0;
      if (sel_hit_c) begin
         rd_map_c = 1'b1;
         case (sel_off_c)
            OFF_ID:      rd_data_c = ID_VALUE;
            OFF_SCRATCH: rd_data_c = scratch_q;
            OFF_CTRL:    rd_data_c = ctrl_q;
            OFF_STATUS:  rd_data_c = {i_status_live, sticky_q};
            OFF_CYCLE:   rd_data_c = cycle_q;
`ifdef DBG_APB_REGS_WAIT_EN
            OFF_WAIT:    rd_data_c = DATA_W'(wait_q);
`endif
            default:     rd_map_c = 1'b0;
         endcase
      end
   end

   // Transfer FSM: next state, latches and response strobes
   always_comb begin
      state_d  = state_q;
      hit_d    = hit_q;
      off_d    = off_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      cnt_d    = cnt_q;
      pready_d = 1'b0;
      prdata_d = '0;
      decerr_d = 1'b0;
      commit_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_penable) begin
               hit_d   = in_hit_c;
               off_d   = i_paddr[7:2];
               write_d = i_pwrite;
               wdata_d = i_pwdata;
               if (wait_cnt_c != '0) begin
                  state_d = ST_WAIT;
                  cnt_d   = wait_cnt_c;
               end else begin
                  state_d  = ST_RESP;
                  pready_d = 1'b1;
                  prdata_d = rd_data_c;
                  decerr_d = ~rd_map_c;
               end
            end
         end
         ST_WAIT: begin
            if (!i_penable) begin
               state_d = ST_IDLE;
            end else if (cnt_q == WAIT_W'(1)) begin
               state_d  = ST_RESP;
               pready_d = 1'b1;
               prdata_d = rd_data_c;
               decerr_d = ~rd_map_c;
            end else begin
               cnt_d = cnt_q - WAIT_W'(1);
            end
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            commit_c = write_q & hit_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Register file next state; set pulses win over W1C, writes to CYCLE win over increment
   always_comb begin
      scratch_d = scratch_q;
      ctrl_d    = ctrl_q;
      cycle_d   = cycle_q + 32'd1;
      w1c_c     = '0;
`ifdef DBG_APB_REGS_WAIT_EN
      wait_d    = wait_q;
`endif
      if (commit_c) begin
         case (off_q)
            OFF_SCRATCH: scratch_d = wdata_q;
            OFF_CTRL:    ctrl_d    = wdata_q;
            OFF_STATUS:  w1c_c     = wdata_q[STATUS_STICKY_W-1:0];
            OFF_CYCLE:   cycle_d   = '0;
`ifdef DBG_APB_REGS_WAIT_EN
            OFF_WAIT:    wait_d    = wdata_q[WAIT_W-1:0];
`endif
            default: ;
         endcase
      end
      sticky_d = (sticky_q & ~w1c_c) | i_status_set;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         hit_q     <= 1'b0;
         off_q     <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         decerr_q  <= 1'b0;
         scratch_q <= '0;
         ctrl_q    <= '0;
         cycle_q   <= '0;
         sticky_q  <= '0;
`ifdef DBG_APB_REGS_WAIT_EN
         wait_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         hit_q     <= hit_d;
         off_q     <= off_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         decerr_q  <= decerr_d;
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         cycle_q   <= cycle_d;
         sticky_q  <= sticky_d;
`ifdef DBG_APB_REGS_WAIT_EN
         wait_q    <= wait_d;
`endif
      end
   end

   assign o_pready = pready_q;
   assign o_prdata = prdata_q;
   assign o_ctrl   = ctrl_q;
   assign o_decerr = decerr_q;

endmodule

// File: tb/tb_dbg_apb_regs.sv
// Self-checking bench for dbg_apb_regs: vector table plus hand sequences,
// with a response scoreboard; covers DBG_APB_REGS_WAIT_EN when defined.
module tb_dbg_apb_regs;

   localparam logic [31:0] ID = 32'h0D8C_0001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        pready;
   logic [31:0] prdata, ctrl;
   logic [15:0] status_set, status_live;
   logic        decerr;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_lat = 0;
   logic [31:0] ctrl_in_resp;

   typedef struct {
      logic        chk;
      logic [31:0] rd;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        chk;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   localparam int NV = 16;
   vec_t vecs[NV];

   dbg_apb_regs #(.ID_VALUE(ID), .BASE_ADDR(32'h0000_0000)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_penable(penable), .i_pwrite(pwrite),
      .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(pready), .o_prdata(prdata),
      .o_ctrl(ctrl), .i_status_set(status_set), .i_status_live(status_live),
      .o_decerr(decerr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Response monitor: pops the scoreboard on every completion strobe
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (pready) begin
            if (sb_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL sb_unexpected_pready: got pready=1, required no response pending");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               n_chk++;
               if (decerr !== e.err) begin
                  n_fail++;
                  $display("FAIL sb_decerr: got %b, required %b", decerr, e.err);
               end
               if (e.chk) begin
                  n_chk++;
                  if (prdata !== e.rd) begin
                     n_fail++;
                     $display("FAIL sb_prdata: got %h, required %h", prdata, e.rd);
                  end
               end
            end
         end else begin
            n_chk++;
            if (prdata !== 32'h0 || decerr !== 1'b0) begin
               n_fail++;
               $display("FAIL idle_outputs: got prdata=%h decerr=%b, required 0/0", prdata, decerr);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic chk, input logic [31:0] exp_rd, input logic exp_err,
                       output logic [31:0] rd);
      int lat;
      bit done;
      sb_q.push_back('{chk: chk, rd: exp_rd, err: exp_err});
      penable = 1'b1; pwrite = wr; paddr = addr; pwdata = wdata;
      lat = 0; done = 1'b0; rd = '0;
      while (!done && lat <= 64) begin
         @(posedge clk); #1;
         if (pready) done = 1'b1;
         else        lat++;
      end
      n_chk++;
      if (!done || lat != exp_lat) begin
         n_fail++;
         $display("FAIL latency addr=%h: got %0d cycles (done=%0b), required %0d", addr, lat, done, exp_lat);
      end
      if (!done && sb_q.size() > 0) void'(sb_q.pop_back());
      rd = prdata;
      ctrl_in_resp = ctrl;
      penable = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd, c0, c1;

      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,          1'b1, ID,            1'b0};
      vecs[1]  = '{1'b1, 32'h0000_0008, 32'hA5A5_0F0F,  1'b0, 32'h0,         1'b0};
      vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b1, 32'hA5A5_0F0F, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0004, 32'h1234_5678,  1'b0, 32'h0,         1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,          1'b1, 32'h1234_5678, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0,         1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0003, 32'h0,          1'b1, ID,            1'b0};
      vecs[7]  = '{1'b0, 32'h0000_003C, 32'h0,          1'b1, 32'h0,         1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0108, 32'hDEAD_BEEF,  1'b0, 32'h0,         1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0008, 32'h0,          1'b1, 32'hA5A5_0F0F, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0006, 32'h0,          1'b1, 32'h1234_5678, 1'b0};
`ifdef DBG_APB_REGS_WAIT_EN
      vecs[11] = '{1'b0, 32'h0000_0014, 32'h0,          1'b1, 32'h0,         1'b0};
`else
      vecs[11] = '{1'b0, 32'h0000_0014, 32'h0,          1'b1, 32'h0,         1'b1};
`endif
      vecs[12] = '{1'b0, 32'h0000_000C, 32'h0,          1'b1, 32'h8001_0000, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_00FC, 32'h0,          1'b1, 32'h0,         1'b1};
      vecs[14] = '{1'b1, 32'h0000_000C, 32'hFFFF_FFFF,  1'b0, 32'h0,         1'b0};
      vecs[15] = '{1'b0, 32'h0000_010C, 32'h0,          1'b1, 32'h0,         1'b1};

      rst_n = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      status_set = '0; status_live = 16'h8001;
      repeat (2) @(posedge clk);
      #1;
      check("reset_pready", 32'(pready), 32'h0);
      check("reset_prdata", prdata, 32'h0);
      check("reset_ctrl",   ctrl,   32'h0);
      check("reset_decerr", 32'(decerr), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++)
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].chk, vecs[i].exp_rd, vecs[i].exp_err, rd);

      // CTRL only updates on the edge that ends RESP
      xfer(1'b1, 32'h8, 32'h5A5A_F0F0, 1'b0, 32'h0, 1'b0, rd);
      check("ctrl_during_resp", ctrl_in_resp, 32'hA5A5_0F0F);
      check("ctrl_after_commit", ctrl, 32'h5A5A_F0F0);
      xfer(1'b0, 32'h8, 32'h0, 1'b1, 32'h5A5A_F0F0, 1'b0, rd);

      // Sticky STATUS: set, W1C colliding with set, plain W1C, live bits
      status_set = 16'h0003;
      @(posedge clk); #1;
      status_set = 16'h0000;
      xfer(1'b0, 32'hC, 32'h0, 1'b1, 32'h8001_0003, 1'b0, rd);
      status_set = 16'h0001;
      xfer(1'b1, 32'hC, 32'h0000_0001, 1'b0, 32'h0, 1'b0, rd);
      status_set = 16'h0000;
      xfer(1'b0, 32'hC, 32'h0, 1'b1, 32'h8001_0003, 1'b0, rd);
      xfer(1'b1, 32'hC, 32'h0000_0002, 1'b0, 32'h0, 1'b0, rd);
      xfer(1'b0, 32'hC, 32'h0, 1'b1, 32'h8001_0001, 1'b0, rd);
      status_live = 16'h1234;
      xfer(1'b1, 32'hC, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, rd);
      xfer(1'b0, 32'hC, 32'h0, 1'b1, 32'h1234_0000, 1'b0, rd);
      status_live = 16'h8001;

      // CYCLE: reads 5 cycles apart, then write-clear with 0 and 4 idle cycles
      xfer(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, c0);
      repeat (3) @(posedge clk);
      #1;
      xfer(1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0, c1);
      check("cycle_delta", c1 - c0, 32'd5);
      xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, rd);
      xfer(1'b0, 32'h10, 32'h0, 1'b1, 32'd0, 1'b0, rd);
      xfer(1'b1, 32'h10, 32'h1234_0000, 1'b0, 32'h0, 1'b0, rd);
      repeat (4) @(posedge clk);
      #1;
      xfer(1'b0, 32'h10, 32'h0, 1'b1, 32'd4, 1'b0, rd);

`ifdef DBG_APB_REGS_WAIT_EN
      // WAIT register: the write itself uses the old count
      xfer(1'b1, 32'h14, 32'hFFFF_FFF3, 1'b0, 32'h0, 1'b0, rd);
      exp_lat = 3;
      xfer(1'b0, 32'h14, 32'h0, 1'b1, 32'h0000_0003, 1'b0, rd);
      xfer(1'b0, 32'h0,  32'h0, 1'b1, ID,            1'b0, rd);
      xfer(1'b0, 32'h3C, 32'h0, 1'b1, 32'h0,         1'b1, rd);
      xfer(1'b1, 32'h14, 32'h0000_000F, 1'b0, 32'h0, 1'b0, rd);
      exp_lat = 15;
      // Start a CTRL write and reset while still in WAIT
      penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hCAFE_F00D;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("wait_no_pready", 32'(pready), 32'h0);
      end
`else
      // Start a CTRL write and reset during its RESP cycle, before the commit edge
      penable = 1'b1; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      check("abort_resp_seen", 32'(pready), 32'h1);
`endif
      rst_n = 1'b0;
      #1;
      check("abort_pready", 32'(pready), 32'h0);
      check("abort_ctrl",   ctrl,        32'h0);
      penable = 1'b0;
      @(posedge clk); #1;
      check("abort_ctrl_held", ctrl, 32'h0);
      rst_n = 1'b1;
      exp_lat = 0;
      @(posedge clk); #1;
      xfer(1'b0, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0, rd);
      xfer(1'b0, 32'h4, 32'h0, 1'b1, 32'h0, 1'b0, rd);

      repeat (2) @(posedge clk);
      #1;
      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
